time_set_ctrl: RTL

//  Time-setting sequencer for the digital clock. Debounces the four keys and walks the

---
 rtl/time_set_ctrl_if.sv | 37 +++
 rtl/time_set_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/time_set_ctrl_if.sv
// ---------------------------------------------------------------------------
// time_set_ctrl_if
//   Key inputs and edit-control outputs of the clock time-setting sequencer.
//   slave  : the sequencer (reads raw keys, drives counter controls/display)
//   master : the key/counter side (drives raw keys, observes the controls)
// Signals
//   key_mode/key_ok/key_up/key_down  raw active-low push buttons
//   sel[2:0]    one-hot field under edit {h,m,s}; 000 in RUN
//   inc/dec     one-cycle increment/decrement pulse for the field in sel
//   dis_s/m/h   1 = corresponding counter frozen
//   blink[2:0]  per-field blank request {h,m,s}; 1 = blank digits
//   mode_code   0 RUN, 1 SET_H, 2 SET_M, 3 SET_S
// ---------------------------------------------------------------------------
interface time_set_ctrl_if;
    logic       key_mode;
    logic       key_ok;
    logic       key_up;
    logic       key_down;
    logic [2:0] sel;
    logic       inc;
    logic       dec;
    logic       dis_s;
    logic       dis_m;
    logic       dis_h;
    logic [2:0] blink;
    logic [1:0] mode_code;

    modport master (
        output key_mode, key_ok, key_up, key_down,
        input  sel, inc, dec, dis_s, dis_m, dis_h, blink, mode_code
    );

    modport slave (
        input  key_mode, key_ok, key_up, key_down,
        output sel, inc, dec, dis_s, dis_m, dis_h, blink, mode_code
    );
endinterface

// File: rtl/time_set_ctrl.sv
// ---------------------------------------------------------------------------
// time_set_ctrl
//   Time-setting sequencer for the digital clock. Debounces the four keys,
//   walks the edit field RUN -> SET_H -> SET_M -> SET_S -> RUN, issues inc/dec
//   pulses with auto-repeat, freezes the counters while editing, and drives
//   the field blink and the status-digit mode code.
// Ports
//   clk50  in   50 MHz system clock
//   reset  in   asynchronous, active-low reset
//   bus    slave modport of time_set_ctrl_if (raw keys in, controls out)
// ---------------------------------------------------------------------------
module time_set_ctrl #(
    parameter int unsigned DEBOUNCE_CYC = 1_000_000,
    parameter int unsigned REPEAT_DLY   = 25_000_000,
    parameter int unsigned REPEAT_PER   = 5_000_000,
    parameter int unsigned BLINK_HALF   = 12_500_000,
    parameter int unsigned TIMEOUT_CYC  = 500_000_000
) (
    input  logic           clk50,
    input  logic           reset,
    time_set_ctrl_if.slave bus
);

    localparam int unsigned REP_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int unsigned DW = $clog2(DEBOUNCE_CYC + 1);
    localparam int unsigned RW = $clog2(REP_MAX + 1);
    localparam int unsigned BW = $clog2(BLINK_HALF + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    // key vector bit positions
    localparam int unsigned K_MODE = 0;
    localparam int unsigned K_OK   = 1;
    localparam int unsigned K_UP   = 2;
    localparam int unsigned K_DOWN = 3;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        SET_H = 2'd1,
        SET_M = 2'd2,
        SET_S = 2'd3
    } state_t;

    // -----------------------------------------------------------------------
    // Key conditioning: 2-flop synchroniser, debounce, registered press event
    // -----------------------------------------------------------------------
    logic [3:0]    raw;
    logic [3:0]    sync1;
    logic [3:0]    sync2;
    logic [3:0]    db;      // debounced level, 1 = released
    logic [3:0]    db_d;
    logic [3:0]    ev;      // one-cycle press event (debounced 1->0)
    logic [DW-1:0] dcnt [4];

    assign raw = {bus.key_down, bus.key_up, bus.key_ok, bus.key_mode};

    always_ff @(posedge clk50 or negedge reset) begin
        if (!reset) begin
            sync1 <= '1;
            sync2 <= '1;
            db    <= '1;
            db_d  <= '1;
            ev    <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                dcnt[i] <= '0;
            end
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            db_d  <= db;
            ev    <= db_d & ~db;
            // count consecutive samples that disagree with the accepted level;
            // any agreeing sample restarts the run
            for (int unsigned i = 0; i < 4; i++) begin
                if (sync2[i] == db[i]) begin
                    dcnt[i] <= '0;
                end else if (dcnt[i] == DW'(DEBOUNCE_CYC - 1)) begin
                    db[i]   <= sync2[i];
                    dcnt[i] <= '0;
                end else begin
                    dcnt[i] <= dcnt[i] + DW'(1);
                end
            end
        end
    end

    logic ev_mode, ev_ok, ev_up, ev_dn;
    logic up_low, dn_low;

    assign ev_mode = ev[K_MODE];
    assign ev_ok   = ev[K_OK];
    assign ev_up   = ev[K_UP];
    assign ev_dn   = ev[K_DOWN];
    assign up_low  = ~db[K_UP];
    assign dn_low  = ~db[K_DOWN];

    // -----------------------------------------------------------------------
    // State, idle timer, repeat engine and blink registers
    // -----------------------------------------------------------------------
    state_t        state;
    state_t        nxt;
    logic [TW-1:0] idle;
    logic          dis;
    logic          lock;     // up+down chord seen; held until both released
    logic          armed;    // auto-repeat active for dir_up's key
    logic          dir_up;
    logic          first;    // next repeat uses REPEAT_DLY instead of REPEAT_PER
    logic [RW-1:0] rcnt;
    logic [BW-1:0] bcnt;
    logic          bphase;

    logic in_set;
    logic change;
    logic timeout;
    logic block;
    logic rep_hit;
    logic pulse_ok;
    logic up_fire;
    logic dn_fire;
    logic ev_fire;
    logic [2:0] sel_c;

    always_comb begin
        in_set  = (state != RUN);
        timeout = in_set && (idle == TW'(TIMEOUT_CYC - 1));

        nxt = state;
        unique case (state)
            RUN:   if (ev_mode) nxt = SET_H;
            SET_H: if (ev_ok) nxt = RUN; else if (ev_mode) nxt = SET_M; else if (timeout) nxt = RUN;
            SET_M: if (ev_ok) nxt = RUN; else if (ev_mode) nxt = SET_S; else if (timeout) nxt = RUN;
            SET_S: if (ev_ok) nxt = RUN; else if (ev_mode) nxt = RUN;   else if (timeout) nxt = RUN;
        endcase
        change = (nxt != state);

        // chord lockout takes effect in the very cycle both keys read low
        block   = (up_low && dn_low) || lock;
        rep_hit = first ? (rcnt == RW'(REPEAT_DLY - 1)) : (rcnt == RW'(REPEAT_PER - 1));

        // no pulse in RUN, in a state-change cycle, or while chorded;
        // the key level gate makes release stop repeats immediately
        pulse_ok = in_set && !change && !block;
        up_fire  = pulse_ok && up_low && (ev_up || (armed && dir_up && rep_hit));
        dn_fire  = pulse_ok && dn_low && !up_fire && (ev_dn || (armed && !dir_up && rep_hit));
        ev_fire  = (up_fire && ev_up) || (dn_fire && ev_dn);

        sel_c = '0;
        unique case (state)
            RUN:   sel_c = 3'b000;
            SET_H: sel_c = 3'b100;
            SET_M: sel_c = 3'b010;
            SET_S: sel_c = 3'b001;
        endcase
    end

    always_ff @(posedge clk50 or negedge reset) begin
        if (!reset) begin
            state <= RUN;
            dis   <= 1'b0;
            idle  <= '0;
        end else begin
            state <= nxt;
            dis   <= (nxt != RUN);
            if (!in_set || (ev != '0)) begin
                idle <= '0;
            end else begin
                idle <= idle + TW'(1);
            end
        end
    end

    always_ff @(posedge clk50 or negedge reset) begin
        if (!reset) begin
            lock <= 1'b0;
        end else if (up_low && dn_low) begin
            lock <= 1'b1;
        end else if (!up_low && !dn_low) begin
            lock <= 1'b0;
        end
    end

    always_ff @(posedge clk50 or negedge reset) begin
        if (!reset) begin
            armed  <= 1'b0;
            dir_up <= 1'b0;
            first  <= 1'b0;
            rcnt   <= '0;
        end else if (!in_set || change || block) begin
            // a fresh press is required after any of these
            armed <= 1'b0;
            first <= 1'b0;
            rcnt  <= '0;
        end else if (up_fire || dn_fire) begin
            armed  <= 1'b1;
            dir_up <= up_fire;
            first  <= ev_fire;
            rcnt   <= '0;
        end else if (armed && (dir_up ? !up_low : !dn_low)) begin
            armed <= 1'b0;
            rcnt  <= '0;
        end else if (armed) begin
            rcnt <= rcnt + RW'(1);
        end
    end

    always_ff @(posedge clk50 or negedge reset) begin
        if (!reset) begin
            bcnt   <= '0;
            bphase <= 1'b0;
        end else if (!in_set || change || up_fire || dn_fire) begin
            // phase restarts unblanked on field change and on every pulse
            bcnt   <= '0;
            bphase <= 1'b0;
        end else if (bcnt == BW'(BLINK_HALF - 1)) begin
            bcnt   <= '0;
            bphase <= ~bphase;
        end else begin
            bcnt <= bcnt + BW'(1);
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.sel       = sel_c;
    assign bus.inc       = up_fire;
    assign bus.dec       = dn_fire;
    assign bus.dis_s     = dis;
    assign bus.dis_m     = dis;
    assign bus.dis_h     = dis;
    assign bus.blink     = sel_c & {3{bphase}};
    assign bus.mode_code = state;

endmodule
